// File: rtl/blink_pkg.sv
// Shared encodings and counter widths for the LED blink-code transmitter.
package blink_pkg;

  localparam int unsigned UNIT_CNT_W = 32;
  localparam int unsigned UCNT_W     = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_GAP  = 2'd2,
    S_FGAP = 2'd3
  } state_e;

endpackage

// File: rtl/blink_timer.sv
// Phase timer: pulses expired once len_units*UNIT_CYC cycles have elapsed since the last clr.
module blink_timer
  import blink_pkg::*;
#(
  parameter int unsigned UNIT_CYC = 31250000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic [UCNT_W-1:0] len_units,
  output logic              expired
);

  logic [UNIT_CNT_W-1:0] cyc_cnt;
  logic [UCNT_W-1:0]     unit_cnt;
  logic                  tick;

  assign tick    = (cyc_cnt == UNIT_CNT_W'(UNIT_CYC - 1));
  assign expired = tick && (unit_cnt == len_units - UCNT_W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc_cnt  <= '0;
      unit_cnt <= '0;
    end else if (clr) begin
      cyc_cnt  <= '0;
      unit_cnt <= '0;
    end else if (tick) begin
      cyc_cnt  <= '0;
      unit_cnt <= unit_cnt + UCNT_W'(1);
    end else begin
      cyc_cnt <= cyc_cnt + UNIT_CNT_W'(1);
    end
  end

endmodule

// File: rtl/led_blink_tx.sv
// Blink-code transmitter: shows a DATA_W-bit value MSB first on one LED,
// long pulse for 1, short pulse for 0, dark gaps between bits and a longer frame gap.
module led_blink_tx
  import blink_pkg::*;
#(
  parameter int unsigned DATA_W      = 5,
  parameter int unsigned UNIT_CYC    = 31250000,
  parameter int unsigned SHORT_UNITS = 1,
  parameter int unsigned LONG_UNITS  = 3,
  parameter int unsigned GAP_UNITS   = 1,
  parameter int unsigned FGAP_UNITS  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              data_valid,
  input  logic [DATA_W-1:0] data_in,
  output logic              data_ready,
  output logic              busy,
  output logic              frame_done,
  output logic              led_out
);

  localparam int unsigned BIT_W = $clog2(DATA_W + 1);

  state_e            state;
  logic [DATA_W-1:0] sreg;
  logic [BIT_W-1:0]  bits_left;
  logic [UCNT_W-1:0] len_units;
  logic              clr;
  logic              expired;

  always_comb begin
    len_units = '0;
    unique case (state)
      S_ON:    len_units = sreg[DATA_W-1] ? UCNT_W'(LONG_UNITS) : UCNT_W'(SHORT_UNITS);
      S_GAP:   len_units = UCNT_W'(GAP_UNITS);
      S_FGAP:  len_units = UCNT_W'(FGAP_UNITS);
      default: len_units = '0;
    endcase
  end

  // Timer is held cleared while idle and restarts on every phase change.
  assign clr = (state == S_IDLE) || expired;

  blink_timer #(
    .UNIT_CYC (UNIT_CYC)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .clr       (clr),
    .len_units (len_units),
    .expired   (expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      sreg       <= '0;
      bits_left  <= '0;
      data_ready <= 1'b0;
      busy       <= 1'b1;
      frame_done <= 1'b0;
      led_out    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (data_ready && data_valid) begin
            sreg       <= data_in;
            bits_left  <= BIT_W'(DATA_W);
            data_ready <= 1'b0;
            busy       <= 1'b1;
            led_out    <= 1'b1;
            state      <= S_ON;
          end else begin
            data_ready <= 1'b1;
            busy       <= 1'b0;
          end
        end
        S_ON: begin
          if (expired) begin
            led_out   <= 1'b0;
            bits_left <= bits_left - BIT_W'(1);
            // The last bit goes straight into the frame gap.
            state     <= (bits_left == BIT_W'(1)) ? S_FGAP : S_GAP;
          end
        end
        S_GAP: begin
          if (expired) begin
            sreg    <= sreg << 1;
            led_out <= 1'b1;
            state   <= S_ON;
          end
        end
        S_FGAP: begin
          if (expired) begin
            data_ready <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b1;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
